// File: rtl/instr_enc_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : instr_enc_pkg
// Brief   : MIPS encodings, operation index and field helpers for instr_encoder
// Rev     : 1.0
// ============================================================================
package instr_enc_pkg;

  // Operation order matches the control decoder's Type ordering
  typedef enum logic [3:0] {
    OP_LW      = 4'd0,
    OP_SW      = 4'd1,
    OP_BEQ     = 4'd2,
    OP_BNE     = 4'd3,
    OP_ADDI    = 4'd4,
    OP_ANDI    = 4'd5,
    OP_ORI     = 4'd6,
    OP_J       = 4'd7,
    OP_SLL     = 4'd8,
    OP_SRL     = 4'd9,
    OP_SRA     = 4'd10,
    OP_AND     = 4'd11,
    OP_OR      = 4'd12,
    OP_ADD     = 4'd13,
    OP_SUB     = 4'd14,
    OP_ILLEGAL = 4'd15
  } op_e;

  localparam logic [3:0] ILLEGAL_OP = 4'd15;

  localparam logic [5:0] OPC_LW    = 6'b100011;
  localparam logic [5:0] OPC_SW    = 6'b101011;
  localparam logic [5:0] OPC_BEQ   = 6'b000100;
  localparam logic [5:0] OPC_BNE   = 6'b000101;
  localparam logic [5:0] OPC_ADDI  = 6'b001000;
  localparam logic [5:0] OPC_ANDI  = 6'b001100;
  localparam logic [5:0] OPC_ORI   = 6'b001101;
  localparam logic [5:0] OPC_J     = 6'b000010;
  localparam logic [5:0] OPC_RTYPE = 6'b000000;

  localparam logic [5:0] FUNC_SLL  = 6'b000000;
  localparam logic [5:0] FUNC_SRL  = 6'b000010;
  localparam logic [5:0] FUNC_SRA  = 6'b000011;
  localparam logic [5:0] FUNC_ADD  = 6'b100000;
  localparam logic [5:0] FUNC_SUB  = 6'b100010;
  localparam logic [5:0] FUNC_AND  = 6'b100100;
  localparam logic [5:0] FUNC_OR   = 6'b100101;

  typedef struct packed {
    op_e         op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [15:0] imm;
    logic [25:0] target;
  } encReq_t;

  function automatic logic [31:0] iWord(input logic [5:0] opc, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
    return {opc, rs, rt, imm};
  endfunction

  function automatic logic [31:0] rWord(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [4:0] shamt,
                                         input logic [5:0] func);
    return {OPC_RTYPE, rs, rt, rd, shamt, func};
  endfunction

endpackage
`default_nettype wire

// File: rtl/instr_enc_word.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : instr_enc_word
// Brief   : combinational field assembly of one 32-bit MIPS word from S1 fields
// Rev     : 1.0
// ============================================================================
module instr_enc_word
  import instr_enc_pkg::*;
(
  input  encReq_t     req,
  output logic [31:0] word,
  output logic        illegal
);

  always_comb begin
    word    = '0;
    illegal = 1'b0;
    case (req.op)
      OP_LW:   word = iWord(OPC_LW,   req.rs, req.rt, req.imm);
      OP_SW:   word = iWord(OPC_SW,   req.rs, req.rt, req.imm);
      OP_BEQ:  word = iWord(OPC_BEQ,  req.rs, req.rt, req.imm);
      OP_BNE:  word = iWord(OPC_BNE,  req.rs, req.rt, req.imm);
      OP_ADDI: word = iWord(OPC_ADDI, req.rs, req.rt, req.imm);
      OP_ANDI: word = iWord(OPC_ANDI, req.rs, req.rt, req.imm);
      OP_ORI:  word = iWord(OPC_ORI,  req.rs, req.rt, req.imm);
      OP_J:    word = {OPC_J, req.target};
      // Shifts take no rs operand; ALU ops take no shift amount
      OP_SLL:  word = rWord(5'd0, req.rt, req.rd, req.shamt, FUNC_SLL);
      OP_SRL:  word = rWord(5'd0, req.rt, req.rd, req.shamt, FUNC_SRL);
      OP_SRA:  word = rWord(5'd0, req.rt, req.rd, req.shamt, FUNC_SRA);
      OP_AND:  word = rWord(req.rs, req.rt, req.rd, 5'd0, FUNC_AND);
      OP_OR:   word = rWord(req.rs, req.rt, req.rd, 5'd0, FUNC_OR);
      OP_ADD:  word = rWord(req.rs, req.rt, req.rd, 5'd0, FUNC_ADD);
      OP_SUB:  word = rWord(req.rs, req.rt, req.rd, 5'd0, FUNC_SUB);
      default: illegal = 1'b1;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/instr_encoder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : instr_encoder
// Brief   : two-stage valid/ready MIPS assembler feeding instruction memory;
//           INSTR_ENC_CNT_EN enables the delivered-word counter enc_count
// Rev     : 1.0
// ============================================================================
module instr_encoder
  import instr_enc_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              restart,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_op,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_shamt,
  input  logic [15:0]       in_imm,
  input  logic [25:0]       in_target,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              err,
  input  logic              clr_err,
  output logic [15:0]       enc_count
);

  encReq_t           w_inReq;
  encReq_t           r_s1Req;
  logic              r_s1Valid;
  logic              r_s2Valid;
  logic [31:0]       r_outInstr;
  logic [ADDR_W-1:0] r_outAddr;
  logic              r_err;
  logic [31:0]       w_word;
  logic              w_illegal;
  logic              w_s1Adv;
  logic              w_s1Xfer;
  logic              w_outFire;

  assign w_inReq = '{op: op_e'(in_op), rs: in_rs, rt: in_rt, rd: in_rd,
                     shamt: in_shamt, imm: in_imm, target: in_target};

  assign w_s1Adv   = !r_s2Valid || out_ready;
  assign in_ready  = !r_s1Valid || w_s1Adv;
  assign w_s1Xfer  = r_s1Valid && w_s1Adv;
  assign w_outFire = r_s2Valid && out_ready;

  instr_enc_word u_word (
    .req     (r_s1Req),
    .word    (w_word),
    .illegal (w_illegal)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1Valid <= 1'b0;
      r_s1Req   <= '0;
    end else if (restart) begin
      r_s1Valid <= 1'b0;
    end else if (in_ready) begin
      r_s1Valid <= in_valid;
      if (in_valid) r_s1Req <= w_inReq;
    end
  end

  // Illegal ops vanish here: S2 stays empty so no word and no address step
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2Valid  <= 1'b0;
      r_outInstr <= '0;
    end else if (restart) begin
      r_s2Valid <= 1'b0;
    end else if (w_s1Adv) begin
      r_s2Valid <= w_s1Xfer && !w_illegal;
      if (w_s1Xfer && !w_illegal) r_outInstr <= w_word;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         r_outAddr <= '0;
    else if (restart)   r_outAddr <= '0;
    else if (w_outFire) r_outAddr <= r_outAddr + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                  r_err <= 1'b0;
    else if (w_s1Xfer && w_illegal && !restart)  r_err <= 1'b1;
    else if (clr_err)                            r_err <= 1'b0;
  end

`ifdef INSTR_ENC_CNT_EN
  logic [15:0] r_encCount;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                    r_encCount <= '0;
    else if (restart)                              r_encCount <= '0;
    else if (w_outFire && r_encCount != 16'hFFFF)  r_encCount <= r_encCount + 16'd1;
  end

  assign enc_count = r_encCount;
`else
  assign enc_count = '0;
`endif

  assign out_valid = r_s2Valid;
  assign out_instr = r_outInstr;
  assign out_addr  = r_outAddr;
  assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_instr_encoder.sv
`timescale 1ns/1ps
`default_nettype none
// Scoreboard bench for instr_encoder; a second ADDR_W=2 instance shares the
// stimulus so every delivered word also checks the narrow wrapping address.
module tb_instr_encoder;
  import instr_enc_pkg::*;

  logic        clk = 1'b0, rst_n = 1'b0, restart = 1'b0, clr_err = 1'b0;
  logic        in_valid = 1'b0, out_ready = 1'b1;
  logic [3:0]  in_op = '0;
  logic [4:0]  in_rs = '0, in_rt = '0, in_rd = '0, in_shamt = '0;
  logic [15:0] in_imm = '0;
  logic [25:0] in_target = '0;

  wire        in_ready, out_valid, err;
  wire [31:0] out_instr;
  wire [9:0]  out_addr;
  wire [15:0] enc_count;
  wire        in_ready2, out_valid2, err2;
  wire [31:0] out_instr2;
  wire [1:0]  out_addr2;
  wire [15:0] enc_count2;

  instr_encoder #(.ADDR_W(10)) dut (
    .clk(clk), .rst_n(rst_n), .restart(restart), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
    .in_imm(in_imm), .in_target(in_target), .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_addr(out_addr), .err(err), .clr_err(clr_err),
    .enc_count(enc_count)
  );

  instr_encoder #(.ADDR_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .restart(restart), .in_valid(in_valid), .in_ready(in_ready2),
    .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
    .in_imm(in_imm), .in_target(in_target), .out_valid(out_valid2), .out_ready(out_ready),
    .out_instr(out_instr2), .out_addr(out_addr2), .err(err2), .clr_err(clr_err),
    .enc_count(enc_count2)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [9:0]  addr;
  } exp_t;

  exp_t       sbq[$];
  int         checks = 0;
  int         failures = 0;
  int         deliv = 0;
  logic [9:0] expAddr = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
    end
  endtask

  // Monitor: a handshake happens at the coming posedge when sampled true here
  initial begin : monitor
    logic        prevStall;
    logic [31:0] pInstr;
    logic [9:0]  pAddr;
    exp_t        e;
    prevStall = 1'b0;
    pInstr = '0;
    pAddr = '0;
    forever begin
      @(negedge clk);
      #2;
      if (prevStall) begin
        check("stall_valid", {31'd0, out_valid}, 32'd1);
        check("stall_instr", out_instr, pInstr);
        check("stall_addr", {22'd0, out_addr}, {22'd0, pAddr});
      end
      if (rst_n && out_valid && out_ready && !restart) begin
        if (sbq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_word actual=0x%08h required=none", out_instr);
        end else begin
          e = sbq.pop_front();
          check("instr", out_instr, e.instr);
          check("addr", {22'd0, out_addr}, {22'd0, e.addr});
          check("addr_w2", {30'd0, out_addr2}, {30'd0, e.addr[1:0]});
          deliv++;
        end
      end
      prevStall = rst_n && out_valid && !out_ready && !restart;
      pInstr = out_instr;
      pAddr = out_addr;
    end
  end

  task automatic send(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic [4:0] sh, input logic [15:0] imm,
                      input logic [25:0] tgt, input logic [31:0] expW, input bit legal);
    int waitCnt;
    waitCnt = 0;
    @(negedge clk);
    in_valid = 1'b1; in_op = op; in_rs = rs; in_rt = rt; in_rd = rd;
    in_shamt = sh; in_imm = imm; in_target = tgt;
    #1;
    while (!in_ready && waitCnt < 50) begin
      @(negedge clk);
      #1;
      waitCnt++;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout actual=in_ready_low required=accept op=%0d", op);
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      if (legal) begin
        sbq.push_back('{instr: expW, addr: expAddr});
        expAddr++;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  task automatic checkCount(input string name);
`ifdef INSTR_ENC_CNT_EN
    check(name, {16'd0, enc_count}, deliv);
`else
    check(name, {16'd0, enc_count}, 32'd0);
`endif
  endtask

  initial begin : driver
    #12;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_instr", out_instr, 32'd0);
    check("rst_out_addr", {22'd0, out_addr}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_enc_count", {16'd0, enc_count}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Addi with latency check: presented exactly two cycles after accept
    send(OP_ADDI, 5'd0, 5'd8, 5'd0, 5'd0, 16'd5, 26'd0, 32'h20080005, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check("lat_n1_valid", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    #1;
    check("lat_n2_valid", {31'd0, out_valid}, 32'd1);
    check("lat_n2_instr", out_instr, 32'h20080005);

    // Back-to-back Add then Sll (rs=7 forced to 0)
    send(OP_ADD, 5'd1, 5'd2, 5'd3, 5'd9, 16'hFFFF, 26'd0, 32'h00221820, 1'b1);
    send(OP_SLL, 5'd7, 5'd1, 5'd2, 5'd4, 16'hFFFF, 26'd0, 32'h00011100, 1'b1);
    idle(3);

    // Lw held under a 3-cycle output stall, J queued behind it
    @(negedge clk);
    out_ready = 1'b0;
    send(OP_LW, 5'd29, 5'd9, 5'd0, 5'd0, 16'd8, 26'd0, 32'h8FA90008, 1'b1);
    send(OP_J, 5'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'h100000, 32'h08100000, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      check("stall_in_ready", {31'd0, in_ready}, 32'd0);
      check("stall_lw", out_instr, 32'h8FA90008);
    end
    @(negedge clk);
    out_ready = 1'b1;
    idle(3);

    // Illegal op between two legal ops
    check("err_before", {31'd0, err}, 32'd0);
    send(OP_ORI, 5'd2, 5'd3, 5'd0, 5'd0, 16'hBEEF, 26'd0, 32'h3443BEEF, 1'b1);
    send(ILLEGAL_OP, 5'd1, 5'd1, 5'd1, 5'd1, 16'h1234, 26'd0, 32'd0, 1'b0);
    send(OP_SUB, 5'd4, 5'd5, 5'd6, 5'd7, 16'd0, 26'd0, 32'h00853022, 1'b1);
    idle(4);
    check("err_set", {31'd0, err}, 32'd1);
    check("sb_empty_1", sbq.size(), 32'd0);
    checkCount("count_7");
    @(negedge clk);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    #1;
    check("err_clr", {31'd0, err}, 32'd0);

    // Restart during a stall with a concurrent request
    @(negedge clk);
    out_ready = 1'b0;
    send(OP_BEQ, 5'd1, 5'd2, 5'd0, 5'd0, 16'hFFFF, 26'd0, 32'h1022FFFF, 1'b1);
    send(OP_BNE, 5'd1, 5'd2, 5'd0, 5'd0, 16'hFFFF, 26'd0, 32'h1422FFFF, 1'b1);
    @(negedge clk);
    restart = 1'b1;
    in_valid = 1'b1; in_op = OP_ANDI; in_rs = 5'd3; in_rt = 5'd4; in_imm = 16'h00AA;
    @(posedge clk);
    sbq.delete();
    expAddr = '0;
    deliv = 0;
    @(negedge clk);
    restart = 1'b0;
    in_valid = 1'b0;
    #1;
    check("rs_out_valid", {31'd0, out_valid}, 32'd0);
    check("rs_in_ready", {31'd0, in_ready}, 32'd1);
    check("rs_out_addr", {22'd0, out_addr}, 32'd0);
    check("rs_enc_count", {16'd0, enc_count}, 32'd0);
    @(negedge clk);
    #1;
    check("rs_out_valid_2", {31'd0, out_valid}, 32'd0);
    out_ready = 1'b1;

    // Six words after restart: addresses restart at 0 and the narrow copy wraps
    send(OP_SRA, 5'd9, 5'd3, 5'd4, 5'd31, 16'd0, 26'd0, 32'h000327C3, 1'b1);
    send(OP_SW, 5'd1, 5'd2, 5'd0, 5'd0, 16'd4, 26'd0, 32'hAC220004, 1'b1);
    send(OP_AND, 5'd1, 5'd2, 5'd3, 5'd5, 16'd0, 26'd0, 32'h00221824, 1'b1);
    send(OP_OR, 5'd1, 5'd2, 5'd3, 5'd0, 16'd0, 26'd0, 32'h00221825, 1'b1);
    send(OP_SRL, 5'd0, 5'd1, 5'd2, 5'd4, 16'd0, 26'd0, 32'h00011102, 1'b1);
    send(OP_ANDI, 5'd1, 5'd2, 5'd0, 5'd0, 16'h00FF, 26'd0, 32'h302200FF, 1'b1);
    idle(6);
    check("sb_empty_2", sbq.size(), 32'd0);
    check("final_addr", {22'd0, out_addr}, 32'd6);
    checkCount("count_6");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
